// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. The IF stage looks up the fetch PC combinationally
//   and gets a taken/not-taken guess plus the next PC. The EX stage trains
//   the table with resolved branches and jumps. Two saturating statistics
//   counters track training volume and mispredictions.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   lookup_pc           fetch PC to predict for (current cycle)
//   predict_taken       1 when the BTB hits and predicts a redirect
//   predict_pc          predicted next PC (stored target or lookup_pc+4)
//   upd_valid           a resolved instruction is presented for training
//   upd_pc              PC of the resolved instruction
//   upd_is_cond/jal/jalr instruction type bits (jal > jalr > cond)
//   upd_taken           resolved direction
//   upd_target          resolved target
//   upd_mispredict      EX flagged this instruction as mispredicted
//   stat_branches       saturating count of training events
//   stat_mispredicts    saturating count of mispredicted training events

module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_cond,
  input  logic        upd_is_jal,
  input  logic        upd_is_jalr,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    TYPE_COND = 2'd0,
    TYPE_JAL  = 2'd1,
    TYPE_JALR = 2'd2
  } br_type_t;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  br_type_t         type_q   [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             train;
  br_type_t         upd_type;
  logic [1:0]       ctr_upd;

  logic [31:0]      branches_next;
  logic [31:0]      mispredicts_next;

  // The byte-offset bits never select an entry; they are folded here so
  // the lint tools see them consumed.
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  // Lookup path: purely combinational so the IF stage gets its prediction
  // in the same cycle. Reads the registered table, so a same-cycle update
  // to this index is not visible until the next cycle.
  always_comb begin
    predict_taken = 1'b0;
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    if (lk_hit) begin
      case (type_q[lk_idx])
        TYPE_JAL, TYPE_JALR: predict_taken = 1'b1;
        default:             predict_taken = ctr_q[lk_idx][1];
      endcase
    end
    predict_pc = predict_taken ? target_q[lk_idx] : (lookup_pc + 32'd4);
  end

  // Training decode: resolve the instruction type with jal taking
  // precedence over jalr over cond, and work out the counter value an
  // update hit would write. Only conditional branches move the counter.
  always_comb begin
    train    = upd_valid && (upd_is_cond || upd_is_jal || upd_is_jalr);
    upd_type = TYPE_COND;
    if (upd_is_jal) begin
      upd_type = TYPE_JAL;
    end else if (upd_is_jalr) begin
      upd_type = TYPE_JALR;
    end
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    ctr_upd = ctr_q[up_idx];
    if (upd_type == TYPE_COND) begin
      if (upd_taken && (ctr_q[up_idx] != 2'b11)) begin
        ctr_upd = ctr_q[up_idx] + 2'd1;
      end else if (!upd_taken && (ctr_q[up_idx] != 2'b00)) begin
        ctr_upd = ctr_q[up_idx] - 2'd1;
      end
    end
  end

  // Table state. Reset clears valid bits and counters only; tags, targets
  // and types are don't-care while the entry is invalid. A not-taken miss
  // never allocates, so cold not-taken branches cannot evict useful entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (train) begin
      if (up_hit) begin
        type_q[up_idx] <= upd_type;
        ctr_q[up_idx]  <= ctr_upd;
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        type_q[up_idx]   <= upd_type;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Statistics next-state: saturate at all-ones instead of wrapping.
  always_comb begin
    branches_next    = stat_branches;
    mispredicts_next = stat_mispredicts;
    if (train && (stat_branches != 32'hFFFF_FFFF)) begin
      branches_next = stat_branches + 32'd1;
    end
    if (train && upd_mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
      mispredicts_next = stat_mispredicts + 32'd1;
    end
  end

  // Statistics registers, reloaded every cycle from their next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      stat_branches    <= branches_next;
      stat_mispredicts <= mispredicts_next;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed bench for branch_predictor with ENTRIES=16 (index pc[5:2],
//   tag pc[31:6]). Inputs change one time unit after the rising edge and
//   outputs are sampled a further time unit later, clear of the edge.

module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_is_jal;
  logic        upd_is_jalr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_br  = 32'd0;
  logic [31:0] exp_mis = 32'd0;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .predict_pc       (predict_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_cond      (upd_is_cond),
    .upd_is_jal       (upd_is_jal),
    .upd_is_jalr      (upd_is_jalr),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Present one training event for a single clock edge, then drop it.
  // Also advances the expected statistics for a real training event.
  task automatic drive_update(input logic c, input logic j, input logic r,
                              input logic t, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic mis);
    upd_valid      = 1'b1;
    upd_is_cond    = c;
    upd_is_jal     = j;
    upd_is_jalr    = r;
    upd_taken      = t;
    upd_pc         = pc;
    upd_target     = tgt;
    upd_mispredict = mis;
    @(posedge clk);
    #1;
    upd_valid      = 1'b0;
    upd_is_cond    = 1'b0;
    upd_is_jal     = 1'b0;
    upd_is_jalr    = 1'b0;
    upd_mispredict = 1'b0;
    if (c || j || r) begin
      exp_br++;
      if (mis) exp_mis++;
    end
  endtask

  // Put a PC on the lookup port and let the combinational path settle.
  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  // Reset behaviour: misses everywhere, pc+4 (with wrap), stats cleared.
  task automatic test_reset();
    rst            = 1'b1;
    upd_valid      = 1'b0;
    upd_is_cond    = 1'b0;
    upd_is_jal     = 1'b0;
    upd_is_jalr    = 1'b0;
    upd_taken      = 1'b0;
    upd_pc         = 32'd0;
    upd_target     = 32'd0;
    upd_mispredict = 1'b0;
    lookup_pc      = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL reset_in_rst: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    total++;
    if ({stat_branches, stat_mispredicts} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL reset_stats: got %h/%h expected 0/0", stat_branches, stat_mispredicts);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL reset_after: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    look(32'hFFFF_FFFC);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h0}) begin
      bad++;
      $display("[TB] FAIL reset_wrap: got %b/%h expected 0/00000000", predict_taken, predict_pc);
    end
  endtask

  // Conditional branch at 0x100 walked through the counter in both
  // directions, including saturation at 0 and 3 and the rule that a
  // not-taken update leaves the target alone.
  task automatic test_cond_counter();
    drive_update(1, 0, 0, 1, 32'h100, 32'h80, 0);        // alloc ctr=2
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h80}) begin
      bad++;
      $display("[TB] FAIL cond_alloc: got %b/%h expected 1/00000080", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 0, 32'h100, 32'hDEAD_BEE0, 0); // ctr=1
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL cond_nt1: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 0, 32'h100, 32'hDEAD_BEE0, 0); // ctr=0
    drive_update(1, 0, 0, 0, 32'h100, 32'hDEAD_BEE0, 0); // ctr stays 0
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL cond_nt3: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 1, 32'h100, 32'h80, 0);        // ctr=1
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL cond_sat_low: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 1, 32'h100, 32'h80, 0);        // ctr=2
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h80}) begin
      bad++;
      $display("[TB] FAIL cond_retake: got %b/%h expected 1/00000080", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 1, 32'h100, 32'h80, 0);        // ctr=3
    drive_update(1, 0, 0, 1, 32'h100, 32'h80, 0);        // ctr stays 3
    drive_update(1, 0, 0, 0, 32'h100, 32'hDEAD_BEE0, 0); // ctr=2
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h80}) begin
      bad++;
      $display("[TB] FAIL cond_sat_high: got %b/%h expected 1/00000080", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 0, 32'h100, 32'hDEAD_BEE0, 0); // ctr=1
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL cond_down: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    total++;
    if ({stat_branches, stat_mispredicts} !== {exp_br, exp_mis}) begin
      bad++;
      $display("[TB] FAIL cond_stats: got %h/%h expected %h/%h", stat_branches, stat_mispredicts, exp_br, exp_mis);
    end
  endtask

  // Jumps, aliasing/eviction at index 0, and type priority.
  task automatic test_jal_alias();
    drive_update(0, 1, 0, 1, 32'h200, 32'h400, 0);       // evicts 0x100
    look(32'h200);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h400}) begin
      bad++;
      $display("[TB] FAIL jal_hit: got %b/%h expected 1/00000400", predict_taken, predict_pc);
    end
    look(32'h100);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL jal_evict_old: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    look(32'h200 + ENTRIES * 4);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h244}) begin
      bad++;
      $display("[TB] FAIL alias_miss: got %b/%h expected 0/00000244", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 1, 32'h240, 32'h500, 0);
    look(32'h240);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h500}) begin
      bad++;
      $display("[TB] FAIL alias_alloc: got %b/%h expected 1/00000500", predict_taken, predict_pc);
    end
    look(32'h200);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h204}) begin
      bad++;
      $display("[TB] FAIL alias_evict: got %b/%h expected 0/00000204", predict_taken, predict_pc);
    end
    drive_update(0, 0, 1, 1, 32'h208, 32'h1234, 0);
    drive_update(1, 0, 1, 0, 32'h208, 32'hBAD0, 0);      // jalr wins over cond
    look(32'h208);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h1234}) begin
      bad++;
      $display("[TB] FAIL jalr_prio: got %b/%h expected 1/00001234", predict_taken, predict_pc);
    end
    drive_update(1, 1, 0, 1, 32'h20C, 32'h600, 0);
    drive_update(1, 1, 0, 0, 32'h20C, 32'hBAD0, 0);      // jal wins over cond
    look(32'h20C);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h600}) begin
      bad++;
      $display("[TB] FAIL jal_prio: got %b/%h expected 1/00000600", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 0, 32'h20C, 32'hBAD0, 0);      // retyped cond, ctr 2->1
    look(32'h20C);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h210}) begin
      bad++;
      $display("[TB] FAIL retype_cond: got %b/%h expected 0/00000210", predict_taken, predict_pc);
    end
  endtask

  // Not-taken miss, mispredict counting, and an update with no type bit.
  task automatic test_stats();
    drive_update(1, 0, 0, 0, 32'h300, 32'h999, 0);
    look(32'h300);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h304}) begin
      bad++;
      $display("[TB] FAIL nt_no_alloc: got %b/%h expected 0/00000304", predict_taken, predict_pc);
    end
    look(32'h240);
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h500}) begin
      bad++;
      $display("[TB] FAIL nt_keeps_entry: got %b/%h expected 1/00000500", predict_taken, predict_pc);
    end
    drive_update(1, 0, 0, 0, 32'h300, 32'h0, 1);
    total++;
    if ({stat_branches, stat_mispredicts} !== {exp_br, exp_mis}) begin
      bad++;
      $display("[TB] FAIL mispredict_count: got %h/%h expected %h/%h", stat_branches, stat_mispredicts, exp_br, exp_mis);
    end
    drive_update(0, 0, 0, 1, 32'h310, 32'h700, 1);
    total++;
    if ({stat_branches, stat_mispredicts} !== {exp_br, exp_mis}) begin
      bad++;
      $display("[TB] FAIL notype_stats: got %h/%h expected %h/%h", stat_branches, stat_mispredicts, exp_br, exp_mis);
    end
    look(32'h310);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h314}) begin
      bad++;
      $display("[TB] FAIL notype_no_alloc: got %b/%h expected 0/00000314", predict_taken, predict_pc);
    end
  endtask

  // Lookup and update of the same index in one cycle.
  task automatic test_back_to_back();
    lookup_pc      = 32'h100;
    upd_valid      = 1'b1;
    upd_is_cond    = 1'b1;
    upd_taken      = 1'b1;
    upd_pc         = 32'h100;
    upd_target     = 32'h80;
    upd_mispredict = 1'b0;
    #1;
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("[TB] FAIL same_cycle_old: got %b/%h expected 0/00000104", predict_taken, predict_pc);
    end
    @(posedge clk);
    #1;
    upd_valid   = 1'b0;
    upd_is_cond = 1'b0;
    exp_br++;
    #1;
    total++;
    if ({predict_taken, predict_pc} !== {1'b1, 32'h80}) begin
      bad++;
      $display("[TB] FAIL same_cycle_new: got %b/%h expected 1/00000080", predict_taken, predict_pc);
    end
  endtask

  // Statistic saturation from a forced all-ones state, then reset
  // colliding with a training event.
  task automatic test_saturation();
    force dut.stat_branches    = 32'hFFFF_FFFF;
    force dut.stat_mispredicts = 32'hFFFF_FFFF;
    @(posedge clk);
    #2;
    release dut.stat_branches;
    release dut.stat_mispredicts;
    drive_update(1, 0, 0, 1, 32'h104, 32'h90, 1);
    total++;
    if ({stat_branches, stat_mispredicts} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
      bad++;
      $display("[TB] FAIL stat_saturate: got %h/%h expected ffffffff/ffffffff", stat_branches, stat_mispredicts);
    end
    rst            = 1'b1;
    upd_valid      = 1'b1;
    upd_is_cond    = 1'b1;
    upd_taken      = 1'b1;
    upd_pc         = 32'h114;
    upd_target     = 32'h88;
    upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    upd_valid      = 1'b0;
    upd_is_cond    = 1'b0;
    upd_mispredict = 1'b0;
    total++;
    if ({stat_branches, stat_mispredicts} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL rst_stats: got %h/%h expected 0/0", stat_branches, stat_mispredicts);
    end
    look(32'h104);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h108}) begin
      bad++;
      $display("[TB] FAIL rst_clears: got %b/%h expected 0/00000108", predict_taken, predict_pc);
    end
    @(posedge clk);
    #1;
    look(32'h114);
    total++;
    if ({predict_taken, predict_pc} !== {1'b0, 32'h118}) begin
      bad++;
      $display("[TB] FAIL rst_discards_train: got %b/%h expected 0/00000118", predict_taken, predict_pc);
    end
  endtask

  // Scenario sequence; each task leaves the table in a known state for
  // the next one.
  initial begin
    test_reset();
    test_cond_counter();
    test_jal_alias();
    test_stats();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
